// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner IDs, latched request fields.
// Pure declarations; no logic, no latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  // Read data handed to the owner when its response times out.
  localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between IFU and LSU; combinational pick, pointer updated on each taken grant.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin, otherwise LSU has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  logic   ifu_vld,
  input  logic   lsu_vld,
  input  logic   take,
  output owner_e win
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e last_q;

  // Reset value makes LSU the favoured side of the first contested grant.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q <= OWN_IFU;
    end else if (take) begin
      last_q <= win;
    end
  end

  always_comb begin
    win = OWN_LSU;
    if (ifu_vld && lsu_vld) begin
      win = (last_q == OWN_LSU) ? OWN_IFU : OWN_LSU;
    end else if (ifu_vld) begin
      win = OWN_IFU;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rstn, take};

  always_comb win = (ifu_vld && !lsu_vld) ? OWN_IFU : OWN_LSU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter of IFU and LSU onto one memory port; grant in N, mem_req_valid in N+1, response passed through combinationally.
// Requesters are stalled (ready=0) while a transaction is in flight; round-robin via MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        arb_timeout
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, win;
  mem_req_t    req_q, req_new;
  logic [15:0] wait_cnt_q;
  logic        timeout_q;
  logic        grant_en, take, rsp_hit, tmo_hit, done;

  // Grants are withheld while rstn is low so a request is never acknowledged and then dropped.
  assign grant_en = rstn && (state_q == ST_IDLE);
  assign take     = grant_en && (ifu_req_valid || lsu_req_valid);

  mem_arb_pick u_pick (
    .clk     (clk),
    .rstn    (rstn),
    .ifu_vld (ifu_req_valid),
    .lsu_vld (lsu_req_valid),
    .take    (take),
    .win     (win)
  );

  assign ifu_req_ready = take && (win == OWN_IFU);
  assign lsu_req_ready = take && (win == OWN_LSU);

  assign req_new = (win == OWN_IFU) ?
      '{addr: ifu_addr, wen: 1'b0, wdata: 32'h0, wmask: 4'h0} :
      '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};

  // A response in the limit cycle takes precedence over the timeout.
  assign rsp_hit = rstn && (state_q == ST_WAIT) && mem_rsp_valid;
  assign tmo_hit = rstn && (state_q == ST_WAIT) && !mem_rsp_valid && (wait_cnt_q == TMO_LIMIT);
  assign done    = rsp_hit || tmo_hit;

  assign mem_addr    = req_q.addr;
  assign mem_wen     = req_q.wen;
  assign mem_wdata   = req_q.wdata;
  assign mem_wmask   = req_q.wmask;
  assign arb_timeout = timeout_q;

  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rdata     = 32'h0;
    lsu_rsp_valid = 1'b0;
    lsu_rdata     = 32'h0;
    unique case (state_q)
      ST_IDLE: begin
        if (take) state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_IFU) begin
            ifu_rsp_valid = 1'b1;
            ifu_rdata     = rsp_hit ? mem_rdata : TIMEOUT_RDATA;
          end else begin
            lsu_rsp_valid = 1'b1;
            lsu_rdata     = rsp_hit ? mem_rdata : TIMEOUT_RDATA;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IFU;
      req_q      <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q <= win;
        req_q   <= req_new;
      end
      // Held at zero through REQ so WAIT always starts counting from zero.
      if (state_q == ST_REQ) begin
        wait_cnt_q <= '0;
      end else if ((state_q == ST_WAIT) && !done) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, arb_timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: ready after rdy_hold stalled cycles, response rsp_delay cycles after the handshake's next cycle.
  int          rdy_hold = 0, rsp_delay = 0, wait_left = 0, dly = 0;
  logic        rsp_en = 1'b1, late_rsp = 1'b0, pend = 1'b0;
  logic [31:0] rsp_data = 32'h0;

  always begin
    @(posedge clk);
    #2;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;
    if (late_rsp) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = 32'hDEAD_BEEF;
      late_rsp      = 1'b0;
    end else if (pend) begin
      if (dly == 0) begin
        pend = 1'b0;
        if (rsp_en) begin
          mem_rsp_valid = 1'b1;
          mem_rdata     = rsp_data;
        end
      end else begin
        dly--;
      end
    end
    if (mem_req_valid === 1'b1) begin
      if (wait_left > 0) begin
        mem_req_ready = 1'b0;
        wait_left--;
      end else begin
        mem_req_ready = 1'b1;
        pend = 1'b1;
        dly  = rsp_delay;
      end
    end else begin
      mem_req_ready = 1'b0;
      wait_left     = rdy_hold;
    end
  end

  // Reference model: one transaction record (owner, fields, accept cycle, handshake cycle).
  logic        m_act = 1'b0, m_own = 1'b0, m_hs = 1'b0, m_tmo = 1'b0, m_last = 1'b0;
  logic        m_wen = 1'b0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_wmask = 0;
  int          m_acc = 0, m_hs_cyc = 0;

  logic        e_mv, in_wait, d_rsp, d_tmo, gnt, win_l, e_iv, e_lv;
  int          glog[$];
  int          ifu_gnt_cyc, lsu_gnt_cyc, ifu_rsp_cyc, lsu_rsp_cyc, lsu_gnt_n = 0, ifu_rsp_n = 0, mem_vld_n = 0;
  logic [31:0] ifu_rsp_dat, lsu_rsp_dat;

  always @(negedge clk) begin
    if (chk_en) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_l = lsu_req_valid && (!ifu_req_valid || !m_last);
`else
      win_l = lsu_req_valid;
`endif
      gnt     = !m_act && rstn && (ifu_req_valid || lsu_req_valid);
      e_mv    = m_act && !m_hs && (cyc > m_acc);
      in_wait = m_act && m_hs && (cyc > m_hs_cyc);
      d_rsp   = in_wait && rstn && mem_rsp_valid;
      d_tmo   = in_wait && rstn && !mem_rsp_valid && ((cyc - m_hs_cyc - 1) == TMO);
      e_iv    = (d_rsp || d_tmo) && !m_own;
      e_lv    = (d_rsp || d_tmo) && m_own;

      chk("ifu_req_ready", ifu_req_ready, gnt && !win_l);
      chk("lsu_req_ready", lsu_req_ready, gnt && win_l);
      chk("mem_req_valid", mem_req_valid, e_mv);
      chk("ifu_rsp_valid", ifu_rsp_valid, e_iv);
      chk("lsu_rsp_valid", lsu_rsp_valid, e_lv);
      chk("ifu_rdata", ifu_rdata, (e_iv && d_rsp) ? mem_rdata : 32'h0);
      if (!(e_lv && d_rsp && m_wen))
        chk("lsu_rdata", lsu_rdata, (e_lv && d_rsp) ? mem_rdata : 32'h0);
      chk("arb_timeout", arb_timeout, m_tmo);
      if (e_mv) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wen", mem_wen, m_wen);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wmask", mem_wmask, m_wmask);
      end

      if (ifu_req_ready) begin glog.push_back(0); ifu_gnt_cyc = cyc; end
      if (lsu_req_ready) begin glog.push_back(1); lsu_gnt_cyc = cyc; lsu_gnt_n++; end
      if (ifu_rsp_valid) begin ifu_rsp_cyc = cyc; ifu_rsp_dat = ifu_rdata; ifu_rsp_n++; end
      if (lsu_rsp_valid) begin lsu_rsp_cyc = cyc; lsu_rsp_dat = lsu_rdata; end
      if (mem_req_valid) mem_vld_n++;

      if (!rstn) begin
        m_act = 1'b0; m_hs = 1'b0; m_tmo = 1'b0; m_last = 1'b0;
      end else begin
        if (d_rsp || d_tmo) m_act = 1'b0;
        if (d_tmo) m_tmo = 1'b1;
        if (e_mv && mem_req_ready) begin m_hs = 1'b1; m_hs_cyc = cyc; end
        if (gnt) begin
          m_act = 1'b1; m_hs = 1'b0; m_acc = cyc; m_own = win_l; m_last = win_l;
          m_addr  = win_l ? lsu_addr : ifu_addr;
          m_wen   = win_l ? lsu_wen : 1'b0;
          m_wdata = win_l ? lsu_wdata : 32'h0;
          m_wmask = win_l ? lsu_wmask : 4'h0;
        end
      end
    end
  end

  // Issues ni IFU and nl LSU requests, each valid held until granted.
  task automatic run_req(input int ni, input int nl, input logic [31:0] ia, input logic [31:0] la,
                         input logic lw, input logic [31:0] lwd, input logic [3:0] lm);
    int n = 0;
    ifu_addr = ia; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lm;
    ifu_req_valid = (ni > 0); lsu_req_valid = (nl > 0);
    while ((ni > 0 || nl > 0) && n < 200) begin
      #2;
      if (ifu_req_ready) ni--;
      if (lsu_req_ready) nl--;
      step();
      ifu_req_valid = (ni > 0);
      lsu_req_valid = (nl > 0);
      n++;
    end
    tests++;
    if (ni > 0 || nl > 0) begin
      fails++;
      $display("FAIL req_grant: %0d ifu / %0d lsu requests still ungranted, required 0", ni, nl);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_act && n < 100) begin step(); n++; end
    tests++;
    if (m_act) begin
      fails++;
      $display("FAIL wait_idle: transaction still open after %0d cycles, required completion", n);
    end
    step();
  endtask

  int exp_g[4];
  int r0, g0;

  initial begin
    rstn = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_addr = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 0;
    repeat (3) step();
    chk_en = 1'b1;
    step();
    rstn = 1'b1;
    #2;
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_arb_timeout", arb_timeout, 1'b0);
    chk("rst_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
    step();

    // Lone fetch, 1-cycle memory.
    rsp_data = 32'h0000_0413;
    run_req(1, 0, 32'h8000_0000, 0, 0, 0, 0);
    wait_idle();
    chk("t1_latency", ifu_rsp_cyc - ifu_gnt_cyc, 2);
    chk("t1_rdata", ifu_rsp_dat, 32'h0000_0413);

    // Simultaneous requests.
    glog.delete();
    rsp_data = 32'h0000_1111;
    run_req(1, 1, 32'h8000_0004, 32'h8000_2000, 1'b0, 0, 0);
    wait_idle();
    chk("t2_grants", glog.size(), 2);
    chk("t2_first_lsu", glog[0], 1);
    chk("t2_then_ifu", glog[1], 0);

    glog.delete();
    run_req(2, 2, 32'h8000_0008, 32'h8000_2004, 1'b0, 0, 0);
    wait_idle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = '{1, 0, 1, 0};
`else
    exp_g = '{1, 1, 0, 0};
`endif
    chk("t2b_grants", glog.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2b_order%0d", i), glog[i], exp_g[i]);

    // Store with memory stalling 3 cycles.
    rdy_hold = 3; mem_vld_n = 0;
    run_req(0, 1, 0, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF);
    wait_idle();
    rdy_hold = 0;
    chk("t3_req_cycles", mem_vld_n, 4);
    chk("t3_rsp_latency", lsu_rsp_cyc - lsu_gnt_cyc, 5);

    // Response in the very cycle the counter hits the limit.
    rsp_delay = 4; rsp_data = 32'hCAFE_F00D;
    run_req(0, 1, 0, 32'h8000_3000, 1'b0, 0, 0);
    wait_idle();
    rsp_delay = 0;
    chk("t4_latency", lsu_rsp_cyc - lsu_gnt_cyc, 6);
    chk("t4_rdata", lsu_rsp_dat, 32'hCAFE_F00D);
    chk("t4_no_timeout", arb_timeout, 1'b0);

    // Silent memory -> timeout.
    rsp_en = 1'b0;
    run_req(1, 0, 32'h8000_0100, 0, 0, 0, 0);
    wait_idle();
    chk("t5_latency", ifu_rsp_cyc - ifu_gnt_cyc, 2 + TMO);
    chk("t5_rdata", ifu_rsp_dat, 32'h0);
    repeat (3) step();
    chk("t5_sticky", arb_timeout, 1'b1);

    // Reset mid-WAIT, then a stray late response.
    r0 = ifu_rsp_n;
    run_req(1, 0, 32'h8000_0200, 0, 0, 0, 0);
    step(); step();
    rstn = 1'b0;
    step();
    rstn = 1'b1; late_rsp = 1'b1;
    repeat (3) step();
    chk("t6_no_rsp", ifu_rsp_n, r0);
    chk("t6_timeout_clr", arb_timeout, 1'b0);
    rsp_en = 1'b1; rsp_data = 32'h0010_0073;
    run_req(1, 0, 32'h8000_0010, 0, 0, 0, 0);
    wait_idle();
    chk("t6_after_latency", ifu_rsp_cyc - ifu_gnt_cyc, 2);
    chk("t6_after_rdata", ifu_rsp_dat, 32'h0010_0073);

    // LSU valid raised and dropped while busy is never granted.
    rdy_hold = 3; g0 = lsu_gnt_n;
    run_req(1, 0, 32'h8000_0300, 0, 0, 0, 0);
    lsu_addr = 32'h8000_4000; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
    step(); step();
    lsu_req_valid = 1'b0;
    wait_idle();
    rdy_hold = 0;
    repeat (2) step();
    chk("t7_dropped", lsu_gnt_n, g0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of WAIT cycles without a memory response before abort (range 1..65535).
REQ-002 SHALL have these clock and reset ports:
- clk  in  1  sole clock; all state updates on posedge clk.
- rstn  in  1  reset, synchronous active-low.
REQ-003 SHALL have these instruction-fetch requester (IFU) ports:
- ifu_req_valid  in  1  fetch request.
- ifu_req_ready  out  1  fetch request accepted this cycle.
- ifu_addr  in  32  fetch address.
- ifu_rsp_valid  out  1  fetch response.
- ifu_rdata  out  32  fetched instruction.
REQ-004 SHALL have these load/store requester (LSU) ports:
- lsu_req_valid  in  1  load/store request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  32  data address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  32  store data.
- lsu_wmask  in  4  byte write mask.
- lsu_rsp_valid  out  1  load data or store acknowledge.
- lsu_rdata  out  32  load data.
REQ-005 SHALL have these shared memory port (MEM) ports:
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  32  address.
- mem_wen  out  1  write enable.
- mem_wdata  out  32  write data.
- mem_wmask  out  4  byte mask.
- mem_rsp_valid  in  1  memory response.
- mem_rdata  in  32  read data.
REQ-006 SHALL have this status port:
- arb_timeout  out  1  sticky: a response timeout has occurred.

Function
REQ-007 SHALL implement FSM states IDLE, REQ, WAIT; at most one transaction is outstanding.
REQ-008 IDLE: when any req_valid is high, SHALL assert ready to exactly one winner (combinationally), latch its addr/wen/wdata/wmask and owner ID, and go to REQ next cycle.
REQ-009 SHALL drive mem_req_valid=1 in REQ only; the latched fields stay stable on mem_* until handshake (mem_req_valid & mem_req_ready), then move to WAIT.
REQ-010 Latency: a request accepted in cycle N SHALL appear on mem_req_valid in cycle N+1; with mem_req_ready=1 and a 1-cycle memory, rsp_valid is seen in cycle N+2.
REQ-011 WAIT: on mem_rsp_valid SHALL pass mem_rdata to the owner's rdata and pulse the owner's rsp_valid for 1 cycle (same cycle, combinational); the FSM returns to IDLE.
REQ-012 Stores SHALL also complete via mem_rsp_valid; lsu_rdata is don't-care for stores.
REQ-013 Non-owner rsp_valid SHALL remain 0; rdata outputs SHALL be 0 when their rsp_valid is 0.
REQ-014 mem_rsp_valid in IDLE or REQ SHALL be ignored.
REQ-015 WAIT cycle counter (16-bit, cleared on WAIT entry): on reaching TIMEOUT_CYCLES without a response, SHALL pulse the owner rsp_valid with rdata=32'h0, set arb_timeout, and return to IDLE.
REQ-016 A response arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: it is a normal completion with no timeout.
REQ-017 Both ready outputs SHALL be 0 in REQ and WAIT.
REQ-018 A requester whose valid drops before it is granted SHALL be ignored.

Reset
REQ-019 On rstn=0 at posedge clk, SHALL set: FSM=IDLE; counter=0; arb_timeout=0; all ready/rsp_valid/mem_req_valid=0; latched fields=0; round-robin pointer favours LSU.
REQ-020 Reset mid-REQ or mid-WAIT SHALL abandon the transaction silently; no rsp_valid is generated afterwards for it.

Configuration
REQ-021 Macro MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, LSU wins whenever both are valid.
REQ-022 Macro MEM_ARB_ROUND_ROBIN_EN defined: when both are valid, the requester not granted last wins; the pointer updates on each grant; a single valid requester always wins.

Structure
REQ-023 SHALL place the FSM state enum, owner enum (OWN_IFU, OWN_LSU), and timeout-rdata constant in package mem_arb_pkg.
REQ-024 SHALL place grant selection (priority / round-robin pointer) in sub-module mem_arb_pick; the FSM, latches and counter stay in mem_arbiter.

Verification
REQ-025 Only IFU request, addr 0x80000000, mem_rdata 0x00000413, 1-cycle memory -> ifu_req_ready in cycle N, ifu_rsp_valid in cycle N+2 with ifu_rdata=0x00000413.
REQ-026 Both valid in the same cycle -> fixed build: LSU granted first, then IFU; round-robin build: back-to-back requests alternate LSU, IFU, LSU.
REQ-027 LSU store addr 0x80001000, wdata 0x12345678, wmask 0xF, mem_req_ready held 0 for 3 cycles -> mem_* fields stable all 3 cycles; lsu_rsp_valid after the response.
REQ-028 TIMEOUT_CYCLES=4, no mem_rsp_valid -> owner rsp_valid with rdata=0 after 4 WAIT cycles; arb_timeout=1 and stays 1.
REQ-029 rstn=0 during WAIT, then the late mem_rsp_valid arrives -> no rsp_valid pulse; arb_timeout=0; next IFU request served normally.
